// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: geometry, bus widths and FSM states.
package icache_pkg;

    localparam int unsigned ICACHE_LINE_SIZ = 16;
    localparam int unsigned ICACHE_SIZ      = 16;
    localparam int unsigned ICACHE_LINE_WID = ICACHE_LINE_SIZ * 8;
    localparam int unsigned ADDR_WID        = 32;
    localparam int unsigned DATA_WID        = 32;

    typedef enum logic [1:0] {
        IDLE,
        MISS,
        REFILL
    } icache_state_e;

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a single outstanding line fill.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned LINE_BYTES = ICACHE_LINE_SIZ,
    parameter int unsigned LINES      = ICACHE_SIZ
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    fetch_en,
    input  logic [ADDR_WID-1:0]     fetch_pc,
    output logic                    fetch_hit,
    output logic [DATA_WID-1:0]     fetch_inst,
    output logic                    mem_en,
    output logic [ADDR_WID-1:0]     mem_pc,
    input  logic                    mem_done,
    input  logic [LINE_BYTES*8-1:0] mem_data
);

    localparam int unsigned OFF_W = $clog2(LINE_BYTES);
    localparam int unsigned IDX_W = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_WID - OFF_W - IDX_W;

    icache_state_e state, state_d;

    logic [LINES-1:0]        valid;
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [LINE_BYTES*8-1:0] data_mem [LINES];

    logic [OFF_W-1:0]        req_off;
    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [IDX_W-1:0]        fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic [LINE_BYTES*8-1:0] req_line;
    logic                    lookup_hit;

    logic                    hit_d;
    logic [DATA_WID-1:0]     inst_d;
    logic                    mem_en_d;
    logic [ADDR_WID-1:0]     mem_pc_d;
    logic                    fill_we;

    assign req_off    = fetch_pc[OFF_W-1:0];
    assign req_idx    = fetch_pc[OFF_W +: IDX_W];
    assign req_tag    = fetch_pc[ADDR_WID-1 -: TAG_W];
    assign fill_idx   = mem_pc[OFF_W +: IDX_W];
    assign fill_tag   = mem_pc[ADDR_WID-1 -: TAG_W];
    assign req_line   = data_mem[req_idx];
    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    always_comb begin
        state_d  = state;
        hit_d    = 1'b0;
        inst_d   = fetch_inst;
        mem_en_d = mem_en;
        mem_pc_d = mem_pc;
        fill_we  = 1'b0;
        unique case (state)
            IDLE: begin
                // A pending hit pulse means IFetch still shows the old request this cycle.
                if (fetch_en && !rollback && !fetch_hit) begin
                    if (lookup_hit) begin
                        hit_d  = 1'b1;
                        inst_d = req_line[{req_off, 3'b000} +: DATA_WID];
                    end else begin
                        state_d  = MISS;
                        mem_en_d = 1'b1;
                        mem_pc_d = {fetch_pc[ADDR_WID-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
            end
            MISS: begin
                if (mem_done) begin
                    state_d  = REFILL;
                    mem_en_d = 1'b0;
                    fill_we  = 1'b1;
                end
            end
            REFILL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            valid      <= '0;
            fetch_hit  <= 1'b0;
            fetch_inst <= '0;
            mem_en     <= 1'b0;
            mem_pc     <= '0;
        end else if (rdy) begin
            state      <= state_d;
            fetch_hit  <= hit_d;
            fetch_inst <= inst_d;
            mem_en     <= mem_en_d;
            mem_pc     <= mem_pc_d;
            if (fill_we) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rdy && fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_data;
        end
    end

endmodule
